spi_master: RTL and testbench

- Single-byte SPI initiator; drives sck/ss/mosi toward a peripheral that uses our existing SPI slave, or toward external SPI devices.
- Accepts a byte on a start strobe, performs one 8-bit MSB-first full-duplex transfer, and returns the received byte with a one-cycle done pulse.
- Sits between local control logic (register bank / command FSM) and the board SPI pins.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sck_gen.sv | 49 ++++
 rtl/spi_master.sv | 121 ++++++++++++
 tb/tb_spi_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants and state encoding for the single-byte SPI initiator.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;
  localparam int unsigned BIT_W     = $clog2(SPI_WIDTH);
  localparam int unsigned HALF_W    = 8;
  localparam int unsigned EDGE_W    = 5;
  localparam int unsigned N_EDGES   = 2 * SPI_WIDTH;

  // Mode defaults shared with the existing SPI slave.
  localparam bit SPI_CPOL_DEF = 1'b0;
  localparam bit SPI_CPHA_DEF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer and sck toggle flop; flags leading/trailing/last sck edges.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter bit          CPOL    = SPI_CPOL_DEF,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_xfer,
  output logic o_sck,
  output logic o_tick_c,
  output logic o_lead_c,
  output logic o_trail_c,
  output logic o_last_c
);

  logic [HALF_W-1:0] r_half_ct;
  logic [EDGE_W-1:0] r_edge_ct;
  logic              r_sck;
  logic              w_edge;

  assign o_tick_c  = i_run && (r_half_ct == HALF_W'(CLK_DIV - 1));
  assign w_edge    = o_tick_c && i_xfer;
  // The edge about to be generated is odd (leading) when the count so far is even.
  assign o_lead_c  = w_edge && !r_edge_ct[0];
  assign o_trail_c = w_edge && r_edge_ct[0];
  assign o_last_c  = w_edge && (r_edge_ct == EDGE_W'(N_EDGES - 1));
  assign o_sck     = r_sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half_ct <= '0;
      r_edge_ct <= '0;
      r_sck     <= CPOL;
    end else begin
      r_half_ct <= (!i_run || o_tick_c) ? '0 : r_half_ct + HALF_W'(1);
      if (!i_xfer) begin
        r_edge_ct <= '0;
        r_sck     <= CPOL;
      end else if (w_edge) begin
        r_edge_ct <= r_edge_ct + EDGE_W'(1);
        r_sck     <= ~r_sck;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte, MSB-first, full-duplex SPI initiator with start/busy/done handshake.
module spi_master
  import spi_pkg::*;
#(
  parameter bit          CPOL    = SPI_CPOL_DEF,
  parameter bit          CPHA    = SPI_CPHA_DEF,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SPI_WIDTH-1:0] data_in,
  input  logic                 miso,
  output logic                 mosi,
  output logic                 sck,
  output logic                 ss,
  output logic                 busy,
  output logic                 done,
  output logic [SPI_WIDTH-1:0] data_out
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be within 2..255");
  end

  spi_state_e           r_state;
  logic [SPI_WIDTH-1:0] r_tx;
  logic [SPI_WIDTH-1:0] r_rx;
  logic [BIT_W-1:0]     r_bit_ct;
  logic                 r_mosi;
  logic                 r_ss;
  logic                 r_busy;
  logic                 r_done;
  logic [SPI_WIDTH-1:0] r_data_out;

  logic w_run, w_xfer, w_tick, w_lead, w_trail, w_last, w_sample, w_shift;

  assign w_run    = (r_state != ST_IDLE);
  assign w_xfer   = (r_state == ST_XFER);
  assign w_sample = CPHA ? w_trail : w_lead;
  // With CPHA=0 the first bit is presented in SETUP, so the final trailing edge shifts nothing.
  assign w_shift  = CPHA ? w_lead : (w_trail && !w_last);

  spi_sck_gen #(
    .CPOL    (CPOL),
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .i_xfer    (w_xfer),
    .o_sck     (sck),
    .o_tick_c  (w_tick),
    .o_lead_c  (w_lead),
    .o_trail_c (w_trail),
    .o_last_c  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_bit_ct   <= '0;
      r_mosi     <= 1'b0;
      r_ss       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_SETUP;
            r_ss     <= 1'b0;
            r_busy   <= 1'b1;
            r_bit_ct <= BIT_W'(SPI_WIDTH - 1);
            if (CPHA) begin
              r_tx <= data_in;
            end else begin
              r_mosi <= data_in[SPI_WIDTH-1];
              r_tx   <= {data_in[SPI_WIDTH-2:0], 1'b0};
            end
          end
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_XFER;
        end
        ST_XFER: begin
          if (w_sample) begin
            r_rx[r_bit_ct] <= miso;
            r_bit_ct       <= r_bit_ct - BIT_W'(1);
          end
          if (w_shift) begin
            r_mosi <= r_tx[SPI_WIDTH-1];
            r_tx   <= {r_tx[SPI_WIDTH-2:0], 1'b0};
          end
          if (w_last) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state    <= ST_IDLE;
            r_ss       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_data_out <= r_rx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mosi     = r_mosi;
  assign ss       = r_ss;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: five instances (all CPOL/CPHA modes at CLK_DIV=4, plus CLK_DIV=2)
// against an edge-driven behavioural SPI slave and loopback/tie-high miso options.
module tb_spi_master;

  localparam int N = 5;
  localparam logic [N-1:0] CPOL_V = 5'b01100;
  localparam logic [N-1:0] CPHA_V = 5'b01010;

  logic                clk = 1'b0;
  logic [N-1:0]        rst_n, start, lb, tie, slv_miso;
  logic [N-1:0][7:0]   din;
  wire  [N-1:0]        miso, mosi, sck, ss, busy, done;
  wire  [N-1:0][7:0]   dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign miso = (lb & mosi) | (~lb & (tie | slv_miso));

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_master #(
      .CPOL    (CPOL_V[g]),
      .CPHA    (CPHA_V[g]),
      .CLK_DIV ((g == N - 1) ? 2 : 4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .start    (start[g]),
      .data_in  (din[g]),
      .miso     (miso[g]),
      .mosi     (mosi[g]),
      .sck      (sck[g]),
      .ss       (ss[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .data_out (dout[g])
    );
  end

  function automatic int div_of(input int i);
    return (i == N - 1) ? 2 : 4;
  endfunction

  // Behavioural slave: presents its byte MSB first and records mosi on the mode's sample edge.
  logic [N-1:0] sck_q, ss_q;
  logic [7:0]   slv_tx [N];
  logic [7:0]   slv_rx [N];
  int           slv_in [N], slv_out [N], slv_edges [N], slv_rise [N];

  always @(sck or ss) begin
    for (int i = 0; i < N; i++) begin
      if (ss_q[i] === 1'b1 && ss[i] === 1'b0) begin
        slv_in[i] = 0; slv_out[i] = 0; slv_edges[i] = 0; slv_rise[i] = 0; slv_rx[i] = 8'h00;
        if (!CPHA_V[i]) begin
          slv_miso[i] = slv_tx[i][7];
          slv_out[i]  = 1;
        end
      end else if (ss[i] === 1'b0 && sck[i] !== sck_q[i]) begin
        slv_edges[i]++;
        if (sck[i] === 1'b1) slv_rise[i]++;
        if ((sck[i] != CPOL_V[i]) != CPHA_V[i]) begin
          if (slv_in[i] < 8) begin
            slv_rx[i][7 - slv_in[i]] = mosi[i];
            slv_in[i]++;
          end
        end else if (slv_out[i] < 8) begin
          slv_miso[i] = slv_tx[i][7 - slv_out[i]];
          slv_out[i]++;
        end
      end
    end
    sck_q = sck;
    ss_q  = ss;
  end

  // Launch one transfer on instance i; returns received byte, cycles from ss fall to done,
  // and whether sck sat at CPOL in the last HOLD cycle and the done cycle.
  task automatic run_xfer(input int i, input logic [7:0] d, output logic [7:0] got,
                          output int lat, output logic sck_ok);
    logic prev_sck;
    got = 8'hxx; lat = 0; sck_ok = 1'b0;
    @(negedge clk); start[i] = 1'b1; din[i] = d;
    @(negedge clk); start[i] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      prev_sck = sck[i];
      @(negedge clk); lat++;
      if (done[i]) begin
        got    = dout[i];
        sck_ok = (prev_sck === CPOL_V[i]) && (sck[i] === CPOL_V[i]);
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({ss[i], sck[i], mosi[i], busy[i], done[i], dout[i]} !== {1'b1, CPOL_V[i], 3'b000, 8'h00}) begin
        $display("FAIL reset[%0d]: got ss/sck/mosi/busy/done/dout=%b%b%b%b%b/%h want 1%b000/00",
                 i, ss[i], sck[i], mosi[i], busy[i], done[i], dout[i], CPOL_V[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_loopback();
    logic [7:0] d, got; int lat; logic ok;
    lb[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 8'hA5 : 8'($urandom);
      run_xfer(0, d, got, lat, ok);
      n_checks++;
      if (got !== d) $display("FAIL loop_data: got %h want %h", got, d); else n_pass++;
      n_checks++;
      if (lat !== 72) $display("FAIL loop_latency: got %0d want 72", lat); else n_pass++;
      n_checks++;
      if (slv_rx[0] !== d) $display("FAIL loop_mosi_at_rise: got %h want %h", slv_rx[0], d); else n_pass++;
      n_checks++;
      if (slv_rise[0] !== 8) $display("FAIL loop_rise_count: got %0d want 8", slv_rise[0]); else n_pass++;
    end
  endtask

  task automatic test_modes();
    logic [7:0] d, got; int lat; logic ok;
    for (int i = 0; i < 4; i++) begin
      lb[i] = 1'b0; tie[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        slv_tx[i] = (k == 0) ? 8'h3C : 8'($urandom);
        d         = (k == 0) ? 8'hC3 : 8'($urandom);
        run_xfer(i, d, got, lat, ok);
        n_checks++;
        if (got !== slv_tx[i]) $display("FAIL mode%0d_rx: got %h want %h", i, got, slv_tx[i]); else n_pass++;
        n_checks++;
        if (slv_rx[i] !== d) $display("FAIL mode%0d_slave_rx: got %h want %h", i, slv_rx[i], d); else n_pass++;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL mode%0d_sck_idle: got %b want 1", i, ok); else n_pass++;
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] d, got; int nd;
    lb[0] = 1'b1; got = 8'hxx; nd = 0;
    d = 8'($urandom_range(0, 254));
    @(negedge clk); start[0] = 1'b1; din[0] = d;
    @(negedge clk); start[0] = 1'b0;
    for (int c = 0; c < 200 && slv_edges[0] < 5; c++) @(negedge clk);
    din[0] = 8'hFF; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done[0]) begin nd++; got = dout[0]; end
    end
    n_checks++;
    if (nd !== 1) $display("FAIL ignore_done_count: got %0d want 1", nd); else n_pass++;
    n_checks++;
    if (got !== d) $display("FAIL ignore_data: got %h want %h", got, d); else n_pass++;
    n_checks++;
    if (slv_rx[0] !== d) $display("FAIL ignore_sent: got %h want %h", slv_rx[0], d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    logic [7:0] got [3];
    int gaps [2];
    int nd, nacc, hi;
    logic pss;
    seq = '{8'h01, 8'h02, 8'h03};
    got = '{8'hxx, 8'hxx, 8'hxx};
    gaps = '{-1, -1};
    nd = 0; nacc = 0; hi = 0; pss = 1'b1;
    lb[0] = 1'b1;
    @(negedge clk); start[0] = 1'b1; din[0] = seq[0];
    for (int c = 0; c < 2000 && nd < 3; c++) begin
      @(negedge clk);
      if (pss && !ss[0]) begin
        if (nacc > 0 && nacc <= 2) gaps[nacc-1] = hi;
        nacc++;
        if (nacc < 3) din[0] = seq[nacc];
      end
      if (ss[0]) hi++; else hi = 0;
      if (done[0]) begin
        got[nd] = dout[0];
        nd++;
        if (nd == 3) start[0] = 1'b0;
      end
      pss = ss[0];
    end
    n_checks++;
    if (nd !== 3) $display("FAIL b2b_done_count: got %0d want 3", nd); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got[k] !== seq[k]) $display("FAIL b2b_data%0d: got %h want %h", k, got[k], seq[k]); else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (gaps[k] !== 1) $display("FAIL b2b_ss_gap%0d: got %0d want 1", k, gaps[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, got; int lat, nd; logic ok;
    lb[0] = 1'b1; nd = 0;
    d = 8'($urandom);
    @(negedge clk); start[0] = 1'b1; din[0] = d;
    @(negedge clk); start[0] = 1'b0;
    for (int c = 0; c < 200 && slv_edges[0] < 9; c++) @(negedge clk);
    #1 rst_n[0] = 1'b0;
    #1;
    n_checks++;
    if ({ss[0], sck[0], busy[0], dout[0]} !== {1'b1, CPOL_V[0], 1'b0, 8'h00})
      $display("FAIL rst_mid_state: got ss/sck/busy/dout=%b%b%b/%h want 1%b0/00",
               ss[0], sck[0], busy[0], dout[0], CPOL_V[0]);
    else n_pass++;
    @(negedge clk); rst_n[0] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    n_checks++;
    if (nd !== 0) $display("FAIL rst_mid_no_done: got %0d want 0", nd); else n_pass++;
    d = 8'($urandom);
    run_xfer(0, d, got, lat, ok);
    n_checks++;
    if (got !== d) $display("FAIL rst_mid_after_data: got %h want %h", got, d); else n_pass++;
    n_checks++;
    if (lat !== 72) $display("FAIL rst_mid_after_latency: got %0d want 72", lat); else n_pass++;
  endtask

  task automatic test_div2();
    logic [7:0] d, got; int lat; logic ok;
    lb[4] = 1'b0; tie[4] = 1'b1;
    run_xfer(4, 8'h80, got, lat, ok);
    n_checks++;
    if (got !== 8'hFF) $display("FAIL div2_data: got %h want ff", got); else n_pass++;
    n_checks++;
    if (lat !== 18 * div_of(4)) $display("FAIL div2_latency: got %0d want %0d", lat, 18 * div_of(4)); else n_pass++;
    tie[4] = 1'b0;
    slv_tx[4] = 8'($urandom);
    d = 8'($urandom);
    run_xfer(4, d, got, lat, ok);
    n_checks++;
    if (got !== slv_tx[4]) $display("FAIL div2_rand_rx: got %h want %h", got, slv_tx[4]); else n_pass++;
    n_checks++;
    if (slv_rx[4] !== d) $display("FAIL div2_rand_slave_rx: got %h want %h", slv_rx[4], d); else n_pass++;
  endtask

  initial begin
    rst_n = '0; start = '0; lb = '0; tie = '0; slv_miso = '0; din = '0;
    for (int i = 0; i < N; i++) slv_tx[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = '1;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_modes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_div2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
